sva_goto_rep_engine: RTL and testbench
======================================

SVA_GOTO_REP_ENGINE -- requirements
Module: sva_goto_rep_engine

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 8: number of concurrent attempt slots (>=1).
REQ-002 SHALL have parameter HITS, default 3: b occurrences completing an attempt (goto repetition b[->HITS], >=1).
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ticks an attempt may live after spawn (>=1).
REQ-004 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, exactly as follows.
REQ-006 sys_clk  input  1  system clock, all logic on its rising edge.
REQ-007 sys_rst  input  1  asynchronous active-high reset.
REQ-008 tick  input  1  one-cycle sample strobe (user-clock edge already detected upstream).
REQ-009 b  input  1  monitored signal, sampled when tick is accepted.
REQ-010 start_en  input  1  spawn a new attempt on this tick, sampled with b.
REQ-011 busy  output  1  high while the engine is scanning or spawning.
REQ-012 succ  output  1  one-cycle pulse per completed attempt.
REQ-013 fail  output  1  one-cycle pulse per timed-out attempt.
REQ-014 overflow  output  1  one-cycle pulse when a spawn finds no free slot.
REQ-015 missed  output  1  one-cycle pulse when tick arrives while busy.
REQ-016 active_cnt  output  $clog2(NUM_THREADS+1)  number of live slots.
REQ-017 succ_cnt, fail_cnt  output  CNT_W each  saturating totals of succ and fail pulses.

Function
REQ-018 Slot state SHALL be: active bit, hit count of $clog2(HITS+1) bits, age of $clog2(TIMEOUT+1) bits.
REQ-019 Control FSM SHALL have states IDLE, SCAN, SPAWN; busy SHALL equal (state != IDLE).
REQ-020 In IDLE, tick at cycle t SHALL latch b and start_en, set idx=0, enter SCAN.
REQ-021 SCAN SHALL evaluate slot idx in cycle t+1+idx; after slot NUM_THREADS-1, SHALL enter SPAWN at cycle t+1+NUM_THREADS, then IDLE.
REQ-022 Active slot evaluation: age+1; hit+1 if latched b; if new hit==HITS -> succ, slot freed; else if new age==TIMEOUT -> fail, slot freed; else slot updated.
REQ-023 Inactive slots SHALL be skipped without pulses; success SHALL take priority over timeout in the same tick.
REQ-024 succ/fail pulses SHALL be registered, asserted in the cycle after the slot's evaluation cycle; several pulses per tick are permitted.
REQ-025 SPAWN with latched start_en=0 SHALL do nothing.
REQ-026 SPAWN with start_en=1, HITS==1 and b=1 SHALL pulse succ without allocating a slot.
REQ-027 Otherwise SPAWN SHALL allocate the lowest-index free slot (including slots freed this scan), with hit=b?1:0 and age=0.
REQ-028 If no slot is free, SPAWN SHALL pulse overflow and drop the attempt.
REQ-029 A tick received while busy SHALL be ignored and SHALL pulse missed in the following cycle.
REQ-030 active_cnt SHALL reflect slot changes one cycle after each evaluation or allocation.
REQ-031 succ_cnt and fail_cnt SHALL increment with each pulse and saturate at all ones.

Reset
REQ-032 sys_rst SHALL asynchronously clear all slots, counters and outputs to 0 and force IDLE, including mid-SCAN; no pulse SHALL be emitted for the aborted tick.
REQ-033 The first tick after deassertion SHALL be processed normally.

Configuration
REQ-034 With macro SVA_TIMEOUT_EN defined, REQ-022 timeout checking SHALL apply; without it, age logic SHALL be removed, fail and fail_cnt SHALL be tied to 0, and attempts end only by success or reset.

Verification (NUM_THREADS=4, HITS=3, TIMEOUT=6, SVA_TIMEOUT_EN defined unless noted)
REQ-035 start_en=1 on tick 1 only, b=1,0,1,1 on ticks 1-4 -> one succ pulse during tick-4 scan; succ_cnt=1; active_cnt=0.
REQ-036 start_en=1 on tick 1 only, b=0 for ticks 1-7 -> fail pulse during the 6th tick after spawn; fail_cnt=1.
REQ-037 start_en=1, b=0 on ticks 1-5 -> overflow pulse on tick 5; active_cnt=4.
REQ-038 tick high for two consecutive cycles -> missed pulse once; only the first tick is processed.
REQ-039 sys_rst asserted during SCAN with 3 live slots -> active_cnt=0, busy=0, no succ or fail pulses.
REQ-040 SVA_TIMEOUT_EN undefined, stimulus of REQ-036 -> no fail pulse; active_cnt stays 1.

Source files
------------

// File: rtl/sva_goto_rep_engine.sv
// sva_goto_rep_engine
// Evaluates the goto-repetition sequence b[->HITS] for up to NUM_THREADS
// overlapping attempts. Each accepted tick scans every slot serially, one
// slot per cycle, then spawns a new attempt when start_en was sampled high.
// The optional timeout is compiled in when the macro SVA_TIMEOUT_EN is
// defined. Without it, the age state is removed and attempts end only by
// success or by reset.
module sva_goto_rep_engine #(
    parameter int NUM_THREADS = 8,
    parameter int HITS        = 3,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 16
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst,
    input  logic                               tick,
    input  logic                               b,
    input  logic                               start_en,
    output logic                               busy,
    output logic                               succ,
    output logic                               fail,
    output logic                               overflow,
    output logic                               missed,
    output logic [$clog2(NUM_THREADS+1)-1:0]   active_cnt,
    output logic [CNT_W-1:0]                   succ_cnt,
    output logic [CNT_W-1:0]                   fail_cnt
);

    localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int HIT_W = $clog2(HITS + 1);
    localparam int ACT_W = $clog2(NUM_THREADS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_THREADS - 1);
    localparam logic [HIT_W-1:0] HITS_C   = HIT_W'(HITS);
    localparam logic [ACT_W-1:0] ACT_ONE  = ACT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SPAWN = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               eval_s;
    logic               spawn_s;

    logic [IDX_W-1:0]   idx_r;
    logic               b_r;
    logic               start_r;

    logic [NUM_THREADS-1:0] act_r;
    logic [HIT_W-1:0]       hit_r [NUM_THREADS];

    logic               cur_act_s;
    logic [HIT_W-1:0]   new_hit_s;
    logic               ev_succ_s;
    logic               ev_fail_s;
    logic               ev_free_s;
    logic               ev_upd_s;

    logic               free_found_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               spawn_succ_s;
    logic               spawn_alloc_s;
    logic               spawn_ovf_s;
    logic               succ_ev_s;

    logic               busy_r;
    logic               succ_r;
    logic               overflow_r;
    logic               missed_r;
    logic [ACT_W-1:0]   active_cnt_r;
    logic [CNT_W-1:0]   succ_cnt_r;

`ifdef SVA_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] TIMEOUT_C = AGE_W'(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);

    logic [AGE_W-1:0]   age_r [NUM_THREADS];
    logic [AGE_W-1:0]   new_age_s;
    logic               fail_r;
    logic [CNT_W-1:0]   fail_cnt_r;
`endif

    // Control state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-state phase strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        eval_s      = 1'b0;
        spawn_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                eval_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_SPAWN;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_SPAWN: begin
                spawn_s     = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch the sampled inputs on acceptance and walk the scan index.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx_r   <= {IDX_W{1'b0}};
            b_r     <= 1'b0;
            start_r <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= {IDX_W{1'b0}};
            b_r     <= b;
            start_r <= start_en;
        end else if (eval_s && (idx_r != LAST_IDX)) begin
            idx_r   <= idx_r + IDX_W'(1);
        end
    end

    // Evaluate the slot under the scan index; success outranks timeout.
    always_comb begin
        cur_act_s = act_r[idx_r];
        new_hit_s = hit_r[idx_r] + HIT_W'(b_r);
        ev_succ_s = eval_s && cur_act_s && (new_hit_s == HITS_C);
`ifdef SVA_TIMEOUT_EN
        new_age_s = age_r[idx_r] + AGE_ONE;
        ev_fail_s = eval_s && cur_act_s && !ev_succ_s && (new_age_s == TIMEOUT_C);
`else
        ev_fail_s = 1'b0;
`endif
        ev_free_s = ev_succ_s || ev_fail_s;
        ev_upd_s  = eval_s && cur_act_s && !ev_free_s;
    end

    // Lowest-index free slot, seeing slots freed earlier in this scan.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {IDX_W{1'b0}};
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (!act_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Spawn outcome: immediate success, allocation or overflow.
    always_comb begin
        spawn_succ_s  = spawn_s && start_r && (HITS == 1) && b_r;
        spawn_alloc_s = spawn_s && start_r && !spawn_succ_s && free_found_s;
        spawn_ovf_s   = spawn_s && start_r && !spawn_succ_s && !free_found_s;
        succ_ev_s     = ev_succ_s || spawn_succ_s;
    end

    // Slot storage: free on completion, advance on evaluation, fill on spawn.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            act_r <= {NUM_THREADS{1'b0}};
            for (int i = 0; i < NUM_THREADS; i++) begin
                hit_r[i] <= {HIT_W{1'b0}};
`ifdef SVA_TIMEOUT_EN
                age_r[i] <= {AGE_W{1'b0}};
`endif
            end
        end else if (ev_free_s) begin
            act_r[idx_r] <= 1'b0;
        end else if (ev_upd_s) begin
            hit_r[idx_r] <= new_hit_s;
`ifdef SVA_TIMEOUT_EN
            age_r[idx_r] <= new_age_s;
`endif
        end else if (spawn_alloc_s) begin
            act_r[free_idx_s] <= 1'b1;
            hit_r[free_idx_s] <= HIT_W'(b_r);
`ifdef SVA_TIMEOUT_EN
            age_r[free_idx_s] <= {AGE_W{1'b0}};
`endif
        end
    end

    // Live-slot count, moved on the same edge as the slot change.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            active_cnt_r <= {ACT_W{1'b0}};
        end else if (ev_free_s) begin
            active_cnt_r <= active_cnt_r - ACT_ONE;
        end else if (spawn_alloc_s) begin
            active_cnt_r <= active_cnt_r + ACT_ONE;
        end
    end

    // Registered status pulses and the success total.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy_r     <= 1'b0;
            succ_r     <= 1'b0;
            overflow_r <= 1'b0;
            missed_r   <= 1'b0;
            succ_cnt_r <= {CNT_W{1'b0}};
        end else begin
            busy_r     <= (state_nxt_s != ST_IDLE);
            succ_r     <= succ_ev_s;
            overflow_r <= spawn_ovf_s;
            missed_r   <= tick && (state_r != ST_IDLE);
            if (succ_ev_s && (succ_cnt_r != CNT_MAX)) begin
                succ_cnt_r <= succ_cnt_r + CNT_ONE;
            end
        end
    end

`ifdef SVA_TIMEOUT_EN
    // Registered timeout pulse and the failure total.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fail_r     <= 1'b0;
            fail_cnt_r <= {CNT_W{1'b0}};
        end else begin
            fail_r <= ev_fail_s;
            if (ev_fail_s && (fail_cnt_r != CNT_MAX)) begin
                fail_cnt_r <= fail_cnt_r + CNT_ONE;
            end
        end
    end

    assign fail     = fail_r;
    assign fail_cnt = fail_cnt_r;
`else
    assign fail     = 1'b0;
    assign fail_cnt = {CNT_W{1'b0}};
`endif

    assign busy       = busy_r;
    assign succ       = succ_r;
    assign overflow   = overflow_r;
    assign missed     = missed_r;
    assign active_cnt = active_cnt_r;
    assign succ_cnt   = succ_cnt_r;

endmodule

// File: tb/tb_sva_goto_rep_engine.sv
// Scoreboard bench for sva_goto_rep_engine (NUM_THREADS=4, HITS=3, TIMEOUT=6).
// Stimulus pushes the expected pulse record ({succ,fail,overflow,missed} and
// the counters seen with it); a monitor pops and compares on every pulse.
// Timeout expectations follow the SVA_TIMEOUT_EN macro of the build.
module tb_sva_goto_rep_engine;

    localparam int NT = 4;
    localparam int HT = 3;
    localparam int TO = 6;
    localparam int CW = 2;
    localparam int AW = $clog2(NT + 1);

    localparam logic [3:0] K_SUCC = 4'b1000;
    localparam logic [3:0] K_FAIL = 4'b0100;
    localparam logic [3:0] K_OVF  = 4'b0010;
    localparam logic [3:0] K_MISS = 4'b0001;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          tick;
    logic          b;
    logic          start_en;
    logic          busy;
    logic          succ;
    logic          fail;
    logic          overflow;
    logic          missed;
    logic [AW-1:0] active_cnt;
    logic [CW-1:0] succ_cnt;
    logic [CW-1:0] fail_cnt;

    typedef struct packed {
        logic [3:0]    kind;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic [AW-1:0] ac;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    sva_goto_rep_engine #(
        .NUM_THREADS(NT),
        .HITS       (HT),
        .TIMEOUT    (TO),
        .CNT_W      (CW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tick      (tick),
        .b         (b),
        .start_en  (start_en),
        .busy      (busy),
        .succ      (succ),
        .fail      (fail),
        .overflow  (overflow),
        .missed    (missed),
        .active_cnt(active_cnt),
        .succ_cnt  (succ_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Monitor: every pulse must match the oldest expected record.
    always @(negedge sys_clk) begin
        ev_t got;
        ev_t want;
        if (succ || fail || overflow || missed) begin
            got = {succ, fail, overflow, missed, succ_cnt, fail_cnt, active_cnt};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got kind=%b sc=%0d fc=%0d ac=%0d, required no pulse",
                         got.kind, got.sc, got.fc, got.ac);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL pulse_record: got kind=%b sc=%0d fc=%0d ac=%0d, required kind=%b sc=%0d fc=%0d ac=%0d",
                             got.kind, got.sc, got.fc, got.ac, want.kind, want.sc, want.fc, want.ac);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(input logic [3:0] k, input int sc, input int fc, input int ac);
        exp_q.push_back({k, CW'(sc), CW'(fc), AW'(ac)});
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic do_tick(input logic bv, input logic sv);
        @(negedge sys_clk);
        tick = 1'b1;
        b = bv;
        start_en = sv;
        @(negedge sys_clk);
        tick = 1'b0;
        b = 1'b0;
        start_en = 1'b0;
        wait_idle();
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        tick = 1'b0;
        b = 1'b0;
        start_en = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1;
        tick = 1'b0;
        b = 1'b0;
        start_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Reset state.
        check("rst_busy", int'(busy), 0);
        check("rst_active", int'(active_cnt), 0);
        check("rst_succ_cnt", int'(succ_cnt), 0);
        check("rst_fail_cnt", int'(fail_cnt), 0);

        // b = 1,0,1,1 after one spawn: success during the fourth tick.
        do_tick(1'b1, 1'b1);
        check("a_active_after_spawn", int'(active_cnt), 1);
        do_tick(1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        expect_ev(K_SUCC, 1, 0, 0);
        do_tick(1'b1, 1'b0);
        check("a_succ_cnt", int'(succ_cnt), 1);
        check("a_active_end", int'(active_cnt), 0);

        // b stuck low: timeout on the sixth tick after spawn (if compiled in).
        apply_reset();
        do_tick(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b0);
`ifdef SVA_TIMEOUT_EN
        expect_ev(K_FAIL, 0, 1, 0);
`endif
        do_tick(1'b0, 1'b0);
`ifdef SVA_TIMEOUT_EN
        check("b_active_end", int'(active_cnt), 0);
        check("b_fail_cnt", int'(fail_cnt), 1);
`else
        check("b_active_end", int'(active_cnt), 1);
        check("b_fail_cnt", int'(fail_cnt), 0);
`endif

        // Five spawns into four slots: overflow on the fifth.
        apply_reset();
        for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b1);
        check("c_active_full", int'(active_cnt), 4);
        expect_ev(K_OVF, 0, 0, 4);
        do_tick(1'b0, 1'b1);
        check("c_active_end", int'(active_cnt), 4);

        // Tick held two cycles: one missed pulse, one spawn.
        apply_reset();
        expect_ev(K_MISS, 0, 0, 0);
        @(negedge sys_clk);
        tick = 1'b1;
        b = 1'b0;
        start_en = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        tick = 1'b0;
        start_en = 1'b0;
        wait_idle();
        check("d_active_one_spawn", int'(active_cnt), 1);

        // Hit count and age both reach their limit on one tick: success wins.
        apply_reset();
        do_tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        do_tick(1'b1, 1'b0);
        expect_ev(K_SUCC, 1, 0, 0);
        do_tick(1'b1, 1'b0);
        check("e_fail_cnt", int'(fail_cnt), 0);

        // Pipelined attempts with slot reuse; 2-bit success total saturates.
        apply_reset();
        do_tick(1'b1, 1'b1);
        do_tick(1'b1, 1'b1);
        expect_ev(K_SUCC, 1, 0, 1);
        do_tick(1'b1, 1'b1);
        expect_ev(K_SUCC, 2, 0, 1);
        do_tick(1'b1, 1'b1);
        expect_ev(K_SUCC, 3, 0, 1);
        do_tick(1'b1, 1'b1);
        expect_ev(K_SUCC, 3, 0, 1);
        do_tick(1'b1, 1'b1);
        check("f_succ_cnt_sat", int'(succ_cnt), 3);
        check("f_active_end", int'(active_cnt), 2);

        // Reset mid-scan with three live slots; slot 0 would have succeeded.
        apply_reset();
        do_tick(1'b1, 1'b1);
        do_tick(1'b1, 1'b1);
        do_tick(1'b0, 1'b1);
        check("g_active_live", int'(active_cnt), 3);
        @(negedge sys_clk);
        tick = 1'b1;
        b = 1'b1;
        start_en = 1'b0;
        @(negedge sys_clk);
        tick = 1'b0;
        b = 1'b0;
        check("g_busy_in_scan", int'(busy), 1);
        sys_rst = 1'b1;
        #1;
        check("g_active_async", int'(active_cnt), 0);
        check("g_busy_async", int'(busy), 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (6) @(negedge sys_clk);
        check("g_busy_after", int'(busy), 0);
        check("g_succ_cnt_after", int'(succ_cnt), 0);

        // First ticks after reset are processed normally.
        do_tick(1'b1, 1'b1);
        check("h_active_spawn", int'(active_cnt), 1);
        do_tick(1'b1, 1'b0);
        expect_ev(K_SUCC, 1, 0, 0);
        do_tick(1'b1, 1'b0);
        check("h_succ_cnt", int'(succ_cnt), 1);

        repeat (5) @(negedge sys_clk);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
